// File: rtl/carregador_hd_pkg.sv
// Shared definitions for the HD-to-instruction-memory loader: state encoding,
// default widths and the transfer-size limit.
package carregador_hd_pkg;

   typedef enum logic [2:0] {
      OCIOSO  = 3'd0,
      VALIDA  = 3'd1,
      LEITURA = 3'd2,
      ESPERA  = 3'd3,
      ESCRITA = 3'd4,
      FIM     = 3'd5
   } estado_t;

   localparam int LARGURA_DADO_PAD = 32;
   localparam int PROF_MI_PAD      = 64;
   localparam int MAX_PALAVRAS     = 64;

   // A request is rejected if it is empty, too long, or runs past the last sector.
   function automatic logic transferencia_invalida(input logic [5:0] setor,
                                                   input logic [6:0] num,
                                                   input logic [7:0] limite);
      logic [7:0] soma;
      soma = {2'b00, setor} + {1'b0, num};
      return (num == 7'd0) || ({1'b0, num} > limite) || (soma > limite);
   endfunction

endpackage

// File: rtl/carregador_hd_contador.sv
// Loadable 7-bit word index counter; terminal flags the last word of the
// transfer (index == limite-1).
module contador_palavras (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       carga,
   input  logic [6:0] valor_carga,
   input  logic       incr,
   input  logic [6:0] limite,
   output logic [6:0] indice,
   output logic       terminal
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         indice <= '0;
      else if (carga)
         indice <= valor_carga;
      else if (incr)
         indice <= indice + 7'd1;
   end

   assign terminal = (indice == (limite - 7'd1));

endmodule

// File: rtl/carregador_hd.sv
// Copies a block of words from a simulated HD track/sector range into the
// instruction memory, one word every three cycles.
//
// state   | meaning
// OCIOSO  | idle, waiting for inicio
// VALIDA  | check the latched request, clear the index
// LEITURA | drive hd_le with track/sector of the current word
// ESPERA  | HD data valid, capture it
// ESCRITA | write captured word to MI, advance index
// FIM     | one-cycle pronto, back to idle
module carregador_hd
   import carregador_hd_pkg::*;
#(
   parameter int LARGURA_DADO = LARGURA_DADO_PAD,
   parameter int PROF_MI      = PROF_MI_PAD
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inicio,
   input  logic                    aborta,
   input  logic [3:0]              trilha,
   input  logic [5:0]              setor_ini,
   input  logic [6:0]              num_palavras,
   input  logic [LARGURA_DADO-1:0] hd_dado,
   output logic [3:0]              hd_trilha,
   output logic [5:0]              hd_setor,
   output logic                    hd_le,
   output logic [5:0]              mi_ender,
   output logic [LARGURA_DADO-1:0] mi_dado,
   output logic                    mi_esc,
   output logic                    ocupado,
   output logic                    pronto,
   output logic                    erro
);

   // A shallower MI than the HD sector space tightens the accepted range.
   localparam logic [7:0] LIMITE_MI = (PROF_MI < MAX_PALAVRAS) ? 8'(PROF_MI) : 8'(MAX_PALAVRAS);

   estado_t                 estado, prox;
   logic [3:0]              trilha_r;
   logic [5:0]              setor_r;
   logic [6:0]              num_r;
   logic [LARGURA_DADO-1:0] dado_r;
   logic                    erro_r;

   logic       carga, incr, captura, seta_erro, aceita;
   logic [6:0] indice;
   logic       terminal;
   logic       unused_indice_msb;

   assign aceita = (estado == OCIOSO) && inicio;

   contador_palavras u_contador (
      .clk         (clk),
      .rst_n       (reset),
      .carga       (carga),
      .valor_carga (7'd0),
      .incr        (incr),
      .limite      (num_r),
      .indice      (indice),
      .terminal    (terminal)
   );

   assign unused_indice_msb = indice[6];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado   <= OCIOSO;
         trilha_r <= '0;
         setor_r  <= '0;
         num_r    <= '0;
         dado_r   <= '0;
         erro_r   <= 1'b0;
      end else begin
         estado <= prox;
         if (aceita) begin
            trilha_r <= trilha;
            setor_r  <= setor_ini;
            num_r    <= num_palavras;
            erro_r   <= 1'b0;
         end else if (seta_erro) begin
            erro_r <= 1'b1;
         end
         if (captura)
            dado_r <= hd_dado;
      end
   end

   always_comb begin
      prox      = estado;
      carga     = 1'b0;
      incr      = 1'b0;
      captura   = 1'b0;
      seta_erro = 1'b0;
      case (estado)
         OCIOSO: if (inicio) prox = VALIDA;
         VALIDA: begin
            if (aborta || transferencia_invalida(setor_r, num_r, LIMITE_MI)) begin
               seta_erro = 1'b1;
               prox      = FIM;
            end else begin
               carga = 1'b1;
               prox  = LEITURA;
            end
         end
         LEITURA: begin
            if (aborta) begin
               seta_erro = 1'b1;
               prox      = FIM;
            end else begin
               prox = ESPERA;
            end
         end
         ESPERA: begin
            if (aborta) begin
               seta_erro = 1'b1;
               prox      = FIM;
            end else begin
               captura = 1'b1;
               prox    = ESCRITA;
            end
         end
         ESCRITA: begin
            // The write in this cycle always completes; abort only ends the loop.
            incr = 1'b1;
            if (aborta) begin
               seta_erro = 1'b1;
               prox      = FIM;
            end else if (terminal) begin
               prox = FIM;
            end else begin
               prox = LEITURA;
            end
         end
         FIM:     prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   assign hd_le     = (estado == LEITURA);
   assign hd_trilha = hd_le ? trilha_r : '0;
   assign hd_setor  = hd_le ? (setor_r + indice[5:0]) : '0;
   assign mi_esc    = (estado == ESCRITA);
   assign mi_ender  = mi_esc ? indice[5:0] : '0;
   assign mi_dado   = mi_esc ? dado_r : '0;
   assign ocupado   = (estado != OCIOSO) && (estado != FIM);
   assign pronto    = (estado == FIM);
   assign erro      = erro_r;

endmodule
